// File: rtl/snn_lif_pkg.sv
// snn_lif_pkg: shared FSM states, Q8.8 constants and state-word field offsets for the LIF accumulator
package snn_lif_pkg;
  typedef enum logic [2:0] {IDLE, ACCUM, READ, CALC, WRITE} lif_state_t;
  localparam logic [15:0] V_REST = 16'h2000;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;
  localparam int V_LSB = 0;
  localparam int META_LSB = 16;
endpackage

// File: rtl/lif_state_update.sv
// lif_state_update: combinational leak/add/saturate/threshold of one neuron state word (refractory via LIF_REFRACTORY_EN)
module lif_state_update import snn_lif_pkg::*; #(
  parameter int ACC_WIDTH = 20,
  parameter int LEAK_SHIFT = 4,
  parameter int ACC_SHIFT = 0,
  parameter logic [15:0] THRESHOLD = 16'h4000,
  parameter logic [15:0] V_RESET = V_REST
) (
  input  logic [17:0]                 rdata,
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic [17:0]                 wdata,
  output logic                        spike
);
  logic signed [15:0] v;
  logic [1:0] meta;
  logic signed [23:0] v24, a24, vn;
  logic [15:0] vs;
  logic fire;
  always_comb begin
    v = rdata[V_LSB +: 16];
    meta = rdata[META_LSB +: 2];
    v24 = {{8{v[15]}}, v};
    a24 = {{(24-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    vn = v24 - (v24 >>> LEAK_SHIFT) + (a24 >>> ACC_SHIFT);
    vs = vn > 24'sh007FFF ? Q_MAX : vn < 24'shFF8000 ? Q_MIN : vn[15:0];
    fire = $signed(vs) >= $signed(THRESHOLD);
    wdata = {meta, fire ? V_RESET : vs};
    spike = fire;
`ifdef LIF_REFRACTORY_EN
    if (meta != 2'b00) begin
      wdata = {meta - 2'b01, v};
      spike = 1'b0;
    end else if (fire)
      wdata[META_LSB +: 2] = 2'b11;
`endif
  end
endmodule

// File: rtl/bit_serial_lif_accumulator.sv
// bit_serial_lif_accumulator: gated bit-serial weight accumulation plus one LIF read-modify-write per group
// Optional refractory countdown in the meta field is enabled by defining LIF_REFRACTORY_EN.
module bit_serial_lif_accumulator import snn_lif_pkg::*; #(
  parameter int NUM_STREAMS = 9,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH = 20,
  parameter int STATE_ADDR_WIDTH = 11,
  parameter int LEAK_SHIFT = 4,
  parameter int ACC_SHIFT = 0,
  parameter logic [15:0] THRESHOLD = 16'h4000,
  parameter logic [15:0] V_RESET = V_REST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [STATE_ADDR_WIDTH-1:0] neuron_addr,
  input  logic [NUM_STREAMS-1:0]      spike_mask,
  input  logic                        stream_valid,
  input  logic [NUM_STREAMS-1:0]      bit_streams,
  input  logic                        last_weight,
  output logic                        busy,
  output logic                        a_we,
  output logic [STATE_ADDR_WIDTH-1:0] a_addr,
  output logic [17:0]                 a_wdata,
  input  logic [17:0]                 a_rdata,
  output logic                        spike_valid,
  output logic                        spike,
  output logic [STATE_ADDR_WIDTH-1:0] spike_addr,
  output logic                        frame_err
);
  localparam int CW = $clog2(WEIGHT_WIDTH);
  localparam int PW = $clog2(NUM_STREAMS + 1);
  localparam logic [CW-1:0] MSB = CW'(WEIGHT_WIDTH - 1);
  lif_state_t state, next;
  logic [STATE_ADDR_WIDTH-1:0] addr;
  logic signed [ACC_WIDTH-1:0] acc, acc_next, mag, term;
  logic [CW-1:0] bit_cnt, cnt_next;
  logic [PW-1:0] pop;
  logic [NUM_STREAMS-1:0] gated;
  logic [17:0] wdata_r, upd_wdata;
  logic spike_r, upd_spike;
  always_comb begin
    gated = bit_streams & spike_mask;
    pop = '0;
    for (int i = 0; i < NUM_STREAMS; i++) pop = pop + PW'(gated[i]);
  end
  // the weight MSB carries negative significance in two's complement
  assign mag = ACC_WIDTH'(pop) << bit_cnt;
  assign term = bit_cnt == MSB ? -mag : mag;
  assign acc_next = stream_valid ? acc + term : acc;
  assign cnt_next = !stream_valid ? bit_cnt : bit_cnt == MSB ? '0 : bit_cnt + 1'b1;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? ACCUM : IDLE;
      ACCUM:   next = last_weight ? READ : ACCUM;
      READ:    next = CALC;
      CALC:    next = WRITE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      acc <= '0;
      bit_cnt <= '0;
      frame_err <= 1'b0;
      wdata_r <= '0;
      spike_r <= 1'b0;
    end else begin
      frame_err <= state == ACCUM && last_weight && cnt_next != '0;
      if (state == IDLE && start) begin
        addr <= neuron_addr;
        acc <= '0;
        bit_cnt <= '0;
      end
      if (state == ACCUM) begin
        acc <= acc_next;
        bit_cnt <= cnt_next;
      end
      if (state == CALC) begin
        wdata_r <= upd_wdata;
        spike_r <= upd_spike;
      end
    end
  end
  lif_state_update #(
    .ACC_WIDTH(ACC_WIDTH), .LEAK_SHIFT(LEAK_SHIFT), .ACC_SHIFT(ACC_SHIFT),
    .THRESHOLD(THRESHOLD), .V_RESET(V_RESET)
  ) u_update (
    .rdata(a_rdata), .acc(acc), .wdata(upd_wdata), .spike(upd_spike)
  );
  assign busy = state inside {ACCUM, READ, CALC};
  assign a_we = state == WRITE;
  assign a_addr = addr;
  assign a_wdata = wdata_r;
  assign spike_valid = a_we;
  assign spike = a_we & spike_r;
  assign spike_addr = addr;
endmodule

// File: tb/tb_bit_serial_lif_accumulator.sv
// tb_bit_serial_lif_accumulator: directed and randomized groups checked against an arithmetic LIF model
module tb_bit_serial_lif_accumulator;
  logic clk = 1'b0;
  logic rst, start, stream_valid, last_weight;
  logic [10:0] neuron_addr, a_addr, spike_addr;
  logic [8:0] spike_mask, bit_streams;
  logic busy, a_we, spike_valid, spike, frame_err;
  logic [17:0] a_wdata, a_rdata;
  logic pre_we;
  logic [10:0] pre_addr;
  logic [17:0] pre_data;
  logic [17:0] mem [0:2047];
  logic [17:0] shadow [0:2047];
  logic [7:0] wt [0:7][0:8];
  logic [8:0] mk [0:7];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bit_serial_lif_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .neuron_addr(neuron_addr),
    .spike_mask(spike_mask), .stream_valid(stream_valid), .bit_streams(bit_streams),
    .last_weight(last_weight), .busy(busy), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata), .spike_valid(spike_valid), .spike(spike),
    .spike_addr(spike_addr), .frame_err(frame_err)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // signed weight sum of masked synapses; a truncated word contributes only its sent low bits
  function automatic int model_acc(input int nbits);
    int a = 0;
    for (int w = 0; w * 8 < nbits; w++)
      for (int s = 0; s < 9; s++)
        if (mk[w][s]) begin
          int nb;
          nb = (nbits - w * 8 >= 8) ? 8 : nbits - w * 8;
          a += (nb == 8) ? int'($signed(wt[w][s])) : int'(wt[w][s]) % (1 << nb);
        end
    return a;
  endfunction

  function automatic logic [17:0] model_lif(input logic [17:0] old, input int acc, output bit sp);
    int v, vn;
    logic [1:0] meta;
    v = int'($signed(old[15:0]));
    meta = old[17:16];
    sp = 1'b0;
`ifdef LIF_REFRACTORY_EN
    if (meta != 2'b00) return {meta - 2'b01, old[15:0]};
`endif
    vn = v - (v >>> 4) + acc;
    if (vn > 32767) vn = 32767;
    if (vn < -32768) vn = -32768;
    if (vn >= 16384) begin
      sp = 1'b1;
      vn = 8192;
`ifdef LIF_REFRACTORY_EN
      meta = 2'b11;
`endif
    end
    return {meta, 16'(vn)};
  endfunction

  task automatic preload(input logic [10:0] addr, input logic [17:0] data);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
    shadow[addr] = data;
  endtask

  task automatic set_words(input int n, input logic [7:0] w, input logic [8:0] m);
    for (int i = 0; i < 8; i++) begin
      mk[i] = (i < n) ? m : 9'h000;
      for (int s = 0; s < 9; s++) wt[i][s] = w;
    end
  endtask

  task automatic feed(input logic [10:0] addr, input int nbits, input bit poke_start);
    @(negedge clk);
    start = 1'b1;
    neuron_addr = addr;
    @(negedge clk);
    start = 1'b0;
    neuron_addr = ~addr;
    chk("busy_accum", busy, 1);
    for (int i = 0; i < nbits; i++) begin
      stream_valid = 1'b1;
      spike_mask = mk[i / 8];
      for (int s = 0; s < 9; s++) bit_streams[s] = wt[i / 8][s][i % 8];
      last_weight = (i == nbits - 1);
      start = poke_start && i == 1;
      @(negedge clk);
    end
    stream_valid = 1'b0;
    last_weight = 1'b0;
    start = 1'b0;
    bit_streams = '0;
  endtask

  task automatic run_group(input logic [10:0] addr, input int nbits, input bit poke_start);
    logic [17:0] exp_w;
    bit exp_sp;
    feed(addr, nbits, poke_start);
    exp_w = model_lif(shadow[addr], model_acc(nbits), exp_sp);
    chk("frame_err", frame_err, nbits % 8 != 0);
    chk("we_read", a_we, 0);
    @(negedge clk);
    chk("we_calc", a_we, 0);
    chk("frame_err_once", frame_err, 0);
    @(negedge clk);
    chk("a_we", a_we, 1);
    chk("spike_valid", spike_valid, 1);
    chk("spike", spike, exp_sp);
    chk("spike_addr", spike_addr, addr);
    chk("a_addr", a_addr, addr);
    chk("a_wdata", a_wdata, exp_w);
    chk("busy_write", busy, 0);
    shadow[addr] = exp_w;
    @(negedge clk);
    chk("we_idle", a_we, 0);
    chk("spike_valid_idle", spike_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stream_valid = 1'b0;
    last_weight = 1'b0;
    neuron_addr = '0;
    spike_mask = '0;
    bit_streams = '0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_we", a_we, 0);
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_spike", spike, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_spike_addr", spike_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    rst = 1'b0;

    preload(11'd5, 18'h02000);
    set_words(1, 8'h01, 9'h1FF);
    run_group(11'd5, 8, 1'b0);

    preload(11'd100, 18'h02000);
    set_words(8, 8'h7F, 9'h1FF);
    run_group(11'd100, 64, 1'b0);

    preload(11'd7, 18'h02000);
    set_words(1, 8'h00, 9'h001);
    wt[0][0] = 8'h80;
    run_group(11'd7, 8, 1'b0);

    preload(11'd9, 18'h00100);
    set_words(1, 8'hFF, 9'h000);
    run_group(11'd9, 8, 1'b0);

    preload(11'd12, 18'h02000);
    set_words(1, 8'h01, 9'h1FF);
    run_group(11'd12, 5, 1'b1);

    preload(11'd13, 18'h08000);
    set_words(8, 8'h80, 9'h1FF);
    run_group(11'd13, 64, 1'b0);

    preload(11'd14, {2'b10, 16'h3000});
    set_words(1, 8'h01, 9'h1FF);
    run_group(11'd14, 8, 1'b0);

    preload(11'd20, 18'h01234);
    set_words(1, 8'h01, 9'h1FF);
    feed(11'd20, 8, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", a_we, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    chk("abort_we2", a_we, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem", mem[20], shadow[20]);

    for (int g = 0; g < 12; g++) begin
      logic [10:0] addr;
      int n;
      addr = 11'($urandom_range(0, 2047));
      n = $urandom_range(1, 8);
      for (int w = 0; w < 8; w++) begin
        mk[w] = 9'($urandom);
        for (int s = 0; s < 9; s++) wt[w][s] = 8'($urandom);
      end
      preload(addr, 18'($urandom));
      run_group(addr, n * 8, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_serial_lif_accumulator.md
Name: bit_serial_lif_accumulator

Overview:
- Downstream consumer of the serial synapse streamer's bit-serial output (stream mode 0).
- Per neuron group, it gates each of the 9 weight bit-streams with a presynaptic spike mask and accumulates the signed weight sum LSB-first.
- On last_weight it performs one leaky-integrate-and-fire read-modify-write of that neuron's 18-bit state in neuron state memory (BRAM port A) and emits a spike.

Parameters:
NUM_STREAMS, 9, parallel weight bit-streams (one per synapse)
WEIGHT_WIDTH, 8, signed two's-complement weight bits per word
ACC_WIDTH, 20, signed accumulator width (255 words x 9 x ±128 fits)
STATE_ADDR_WIDTH, 11, neuron state memory address width
LEAK_SHIFT, 4, leak term is v >>> LEAK_SHIFT
ACC_SHIFT, 0, accumulator arithmetic right shift before adding to v
THRESHOLD, 16'h4000, spike threshold on signed Q8.8 v
V_RESET, 16'h2000, post-spike potential

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  pulse: begin a group for neuron_addr
neuron_addr  in  STATE_ADDR_WIDTH  target neuron, captured on start
spike_mask  in  NUM_STREAMS  presynaptic spikes for current word; stable for all 8 bit cycles
stream_valid  in  1  bit_streams valid this cycle
bit_streams  in  NUM_STREAMS  one weight bit per synapse, LSB first
last_weight  in  1  pulse: group's final word done
busy  out  1  group in progress
a_we  out  1  state memory write enable
a_addr  out  STATE_ADDR_WIDTH  state memory address
a_wdata  out  18  {meta[1:0], v[15:0]}
a_rdata  in  18  registered read data, 1-cycle latency
spike_valid  out  1  1-cycle pulse, update committed
spike  out  1  neuron fired (qualified by spike_valid)
spike_addr  out  STATE_ADDR_WIDTH  neuron of this result
frame_err  out  1  1-cycle pulse: last_weight with bit counter != 0

Behaviour:
- Reset (synchronous, rst=1): all outputs 0; state IDLE; accumulator 0; bit counter 0. Reset mid-operation aborts the group, and no write occurs.
- FSM states: IDLE, ACCUM, READ, CALC, WRITE.
- IDLE:
  - start=1 → capture neuron_addr, clear acc and bit_cnt, busy=1, go to ACCUM.
  - stream_valid and last_weight are ignored.
- ACCUM:
  - On each stream_valid: p = popcount(bit_streams & spike_mask), range 0..9.
  - term = p << bit_cnt. At bit_cnt = WEIGHT_WIDTH-1 the term is negated (sign bit).
  - acc += term, sign-extended to ACC_WIDTH.
  - bit_cnt increments and wraps 7→0; each wrap is one word.
  - start is ignored.
- ACCUM exit on last_weight:
  - stream_valid in the same cycle is accumulated first, then exit.
  - If bit_cnt != 0 after that bit, frame_err pulses. Accumulation stops there and the partial value is committed.
  - a_addr = captured address; go to READ.
- READ: wait one cycle for a_rdata.
- CALC: v = a_rdata[15:0] (signed).
  - Compute vn = v - (v >>> LEAK_SHIFT) + (acc >>> ACC_SHIFT) at 24 bits.
  - Saturate vn to [16'h8000, 16'h7FFF].
  - If vn >= THRESHOLD (signed): spike_r=1, vn=V_RESET.
  - Register {meta, vn}; go to WRITE.
- WRITE: a_we=1 for exactly 1 cycle; spike_valid=1; spike=spike_r; spike_addr=address; busy=0; go to IDLE.
- Latency: last_weight → a_we / spike_valid is 3 cycles.
- A new start is accepted in the cycle after WRITE.
- a_we is never high outside WRITE.

Optional Feature:
- Macro: LIF_REFRACTORY_EN.
- Defined: meta[1:0] is a refractory countdown.
  - If read meta != 0: v is unchanged (no leak, no acc), meta decrements, spike=0.
  - On spike: meta is written 2'b11.
- Undefined: meta is written back unchanged and the refractory path is absent.

Decomposition:
- Package snn_lif_pkg holds:
  - FSM state enum lif_state_t.
  - Q8.8 constants: V_REST=16'h2000, Q_MAX, Q_MIN.
  - State word field offsets: V_LSB=0, META_LSB=16.
- One sub-module, lif_state_update: combinational leak/add/saturate/threshold (plus refractory under the macro), instantiated in CALC.

Test Plan:
- One word, all weights 8'h01, mask 9'h1FF, v=0x2000 → acc=9; a_wdata[15:0]=0x1E09; spike=0; a_we 3 cycles after last_weight.
- Eight words of 8'h7F, mask all, v=0x2000 → acc=9144; vn=0x41B8 ≥ 0x4000 → spike=1, a_wdata[15:0]=0x2000, spike_addr=neuron_addr.
- Weight 8'h80 on stream 0 only, mask 9'h001, v=0x2000 → acc=-128; a_wdata[15:0]=0x1D80; spike=0.
- Masked synapses: weights 8'hFF all, mask 9'h000, v=0x0100 → acc=0; a_wdata[15:0]=0x00F0.
- last_weight after 5 stream_valid cycles → frame_err pulses once; write still occurs. start while busy is ignored (spike_addr unchanged).
- rst asserted in READ → no a_we pulse, busy=0 next cycle. With LIF_REFRACTORY_EN and meta=2'b10: v unchanged, a_wdata[17:16]=2'b01.
